psum_rearrange_reader: RTL
==========================

// Module: psum_rearrange_reader
// PURPOSE
//  Read-side sequencer for the psum rearrange buffer. Walks the stored layer in pixel-major, channel-minor order.
//  Drives read_addr to the buffer and takes its combinational data_out in the same cycle.
//  Packs 4 signed bytes per word and streams next-layer ifmap words to the ifmap GLB over a valid/ready handshake.
// PARAMETERS
//  ADDR_W   12    buffer address width
//  DEPTH    3500  buffer depth; C*H*W must be <= DEPTH
//  DIM_W    10    width of the channel/height/width config fields
// PORTS
//  clock         in   1       single clock, rising edge
//  reset         in   1       synchronous, active-high
//  start         in   1       1-cycle request; ignored while busy
//  cfg_channel   in   DIM_W   C, channels stored in buffer
//  cfg_height    in   DIM_W   H
//  cfg_width     in   DIM_W   W
//  read_addr     out  ADDR_W  address to rearrange buffer
//  read_data     in   8       signed byte from buffer at read_addr, same cycle
//  ifmap_data    out  32      packed word; first byte in [7:0]
//  ifmap_valid   out  1       ifmap_data valid
//  ifmap_ready   in   1       GLB accepts when valid&ready
//  busy          out  1       high from accepted start until done
//  done          out  1       1-cycle pulse after last word handshake
// BEHAVIOUR
//  - Buffer layout (fixed): addr(c,y,x) = c*H*W + y*W + x.
//  - Emit order: for y, for x, for c. Byte k of the stream is channel c of pixel (y,x).
//  - Reset: state IDLE; read_addr=0, ifmap_data=0, ifmap_valid=0, busy=0, done=0; pack/out registers cleared.
//  - Reset mid-operation aborts immediately. No done pulse; partial word discarded.
//  - FSM states:
//    - IDLE: start -> latch C,H,W; PLANE=C? no: PLANE=H*W (registered); go FETCH; busy=1.
//    - FETCH: one byte per cycle into pack reg lane (k mod 4).
//      - Address is generated incrementally: coff += PLANE per channel; coff=0 and pix++ at channel wrap. No per-cycle multiply.
//      - Last byte -> FLUSH.
//    - FLUSH: zero-pad the unfilled lanes of a partial pack word and hand it to the output reg; go DRAIN.
//    - DRAIN: wait for the final out-reg handshake; then done=1 for 1 cycle, busy=0, go IDLE.
//  - Two-stage buffering (pack reg + out reg):
//    - A full pack word moves to the out reg when the out reg is empty or is being accepted that cycle.
//    - Otherwise FETCH stalls: read_addr is held and the lane is not written.
//    - ifmap_data/ifmap_valid come from registers; they are stable while valid&!ready.
//  - Latency with ready=1: start accepted at cycle 0; bytes fetched cycles 1..4; first ifmap_valid at cycle 5; one word per 4 cycles after.
//  - Word count = ceil(C*H*W/4). The final word is padded with 0x00 in its unfilled upper lanes.
//  - Any of C,H,W == 0: no reads, no words; done pulses the cycle after start.
//  - C*H*W > DEPTH: truncated at DEPTH bytes; behaviour is defined, not an error.
//  - start while busy: ignored. start with a done pulse in the same cycle: accepted (IDLE re-entered).
//  - read_addr is don't-care outside FETCH but held at its last value.
// TESTING
//  - buffer[i]=i, C=4,H=1,W=2, ready=1 -> words 0x06040200, 0x07050301; first valid at cycle 5; done after 2nd handshake.
//  - C=1,H=1,W=5, buffer[i]=i -> 0x03020100 then 0x00000004 (zero pad); exactly 2 handshakes.
//  - Same as case 1, ready low for 10 cycles while valid -> ifmap_data is stable and read_addr is frozen; no bytes lost or duplicated.
//  - C=0 (H=W=4) -> no ifmap_valid; done pulses the cycle after start; read_addr is never advanced.
//  - reset asserted mid-FETCH, then restart with C=4,H=1,W=2 -> output matches case 1 exactly; no stale word.
//  - start re-pulsed while busy -> ignored; single done; total word count unchanged.

Source files
------------

// File: rtl/psum_rearrange_reader.sv
// Read-side sequencer for the psum rearrange buffer: walks the stored layer pixel-major,
// channel-minor, packs four signed bytes per word and streams them over valid/ready.
module psum_rearrange_reader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 3500,
    parameter int DIM_W  = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIM_W-1:0]         cfg_channel,
    input  logic [DIM_W-1:0]         cfg_height,
    input  logic [DIM_W-1:0]         cfg_width,
    output logic [ADDR_W-1:0]        read_addr,
    input  logic signed [7:0]        read_data,
    output logic [31:0]              ifmap_data,
    output logic                     ifmap_valid,
    input  logic                     ifmap_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int PL_W  = 2 * DIM_W;
    localparam int CO_W  = 3 * DIM_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_n;
    logic                done_q, done_n;
    logic [DIM_W-1:0]    cfg_c;
    logic [PL_W-1:0]     plane;
    logic [DIM_W-1:0]    ch;
    logic [PL_W-1:0]     pix;
    logic [CO_W-1:0]     coff;
    logic [CNT_W-1:0]    kcnt;
    logic [1:0]          lane_p0;
    logic [23:0]         pack_p0;
    logic [31:0]         data_p1;
    logic                vld_p1;

    logic cfg_zero, start_go, out_free, fetch_en, last_byte, drain_ok, flush_load;

    assign cfg_zero   = (cfg_channel == '0) || (cfg_height == '0) || (cfg_width == '0);
    assign start_go   = (state_q == IDLE) && start && !cfg_zero;
    assign out_free   = !vld_p1 || ifmap_ready;
    assign drain_ok   = !vld_p1 || ifmap_ready;
    // The lane-3 byte goes straight into the output word, so it is only read when that word can move.
    assign fetch_en   = (state_q == FETCH) && ((lane_p0 != 2'd3) || out_free);
    assign last_byte  = ((ch == cfg_c - DIM_W'(1)) && (pix == plane - PL_W'(1)))
                        || (kcnt == CNT_W'(DEPTH - 1));
    assign flush_load = (state_q == FLUSH) && (lane_p0 != 2'd0) && out_free;

    assign ifmap_data  = data_p1;
    assign ifmap_valid = vld_p1;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;

    always_comb begin
        state_n = state_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_zero) done_n  = 1'b1;
                    else          state_n = FETCH;
                end
            end
            FETCH: begin
                if (fetch_en && last_byte) state_n = FLUSH;
            end
            FLUSH: begin
                // No partial word left: finish as soon as the last full word is taken.
                if (lane_p0 == 2'd0) begin
                    if (drain_ok) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (out_free) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_ok) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            done_q  <= done_n;
        end
    end

    // Stage p0: address walk and byte fetch into pack lanes
    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_c     <= '0;
            plane     <= '0;
            ch        <= '0;
            pix       <= '0;
            coff      <= '0;
            kcnt      <= '0;
            lane_p0   <= '0;
            pack_p0   <= '0;
            read_addr <= '0;
        end else if (start_go) begin
            cfg_c     <= cfg_channel;
            plane     <= PL_W'(cfg_height) * PL_W'(cfg_width);
            ch        <= '0;
            pix       <= '0;
            coff      <= '0;
            kcnt      <= '0;
            lane_p0   <= '0;
            pack_p0   <= '0;
            read_addr <= '0;
        end else if (fetch_en) begin
            lane_p0 <= lane_p0 + 2'd1;
            kcnt    <= kcnt + CNT_W'(1);
            case (lane_p0)
                2'd0:    pack_p0 <= {16'd0, read_data};
                2'd1:    pack_p0[15:8]  <= read_data;
                2'd2:    pack_p0[23:16] <= read_data;
                default: pack_p0 <= pack_p0;
            endcase
            if (!last_byte) begin
                if (ch == cfg_c - DIM_W'(1)) begin
                    ch        <= '0;
                    coff      <= '0;
                    pix       <= pix + PL_W'(1);
                    read_addr <= ADDR_W'(pix + PL_W'(1));
                end else begin
                    ch        <= ch + DIM_W'(1);
                    coff      <= coff + CO_W'(plane);
                    read_addr <= ADDR_W'(coff + CO_W'(plane) + CO_W'(pix));
                end
            end
        end
    end

    // Stage p1: output word register
    always_ff @(posedge clock) begin
        if (reset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            if (vld_p1 && ifmap_ready) vld_p1 <= 1'b0;
            if (fetch_en && (lane_p0 == 2'd3)) begin
                data_p1 <= {read_data, pack_p0};
                vld_p1  <= 1'b1;
            end else if (flush_load) begin
                data_p1 <= {8'd0, pack_p0};
                vld_p1  <= 1'b1;
            end
        end
    end

endmodule
